// File: rtl/i2c_slave_regfile.sv
// I2C target with an internal byte register file.
// SCL/SDA are oversampled on clk; SDA is driven open-drain through sda_oe.
module i2c_slave_regfile #(
    parameter logic [6:0]   SLAVE_ADDR  = 7'h12,
    parameter int unsigned  NUM_REGS    = 16,
    parameter int unsigned  SYNC_STAGES = 2,
    localparam int unsigned ADDR_W      = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StAddr     = 4'd1,
        StAddrAck  = 4'd2,
        StIndex    = 4'd3,
        StIndexAck = 4'd4,
        StWdata    = 4'd5,
        StWdataAck = 4'd6,
        StRdata    = 4'd7,
        StRdataAck = 4'd8,
        StIgnore   = 4'd9
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_hist_q, sda_hist_q;
    logic [SYNC_STAGES:0]   warm_q;
    logic                   scl_s, sda_s, bus_live;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_in_q, shift_in_d;
    logic [7:0]        shift_out_q, shift_out_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic              sda_oe_q, sda_oe_d;
    logic              phase_q, phase_d;
    logic              rw_q, rw_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        rd_data_q;
    logic              reg_we;
    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        rx_byte, cur_byte, next_byte;
    logic              index_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            warm_q     <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
            warm_q     <= {warm_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Edges are only trusted once the pipeline holds real pin samples, so a
    // reset in the middle of a transfer cannot fabricate a START.
    assign bus_live  = warm_q[SYNC_STAGES];
    assign scl_rise  = bus_live & scl_s & ~scl_hist_q;
    assign scl_fall  = bus_live & ~scl_s & scl_hist_q;
    assign start_det = bus_live & scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = bus_live & scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    assign rx_byte   = {shift_in_q, sda_s};
    assign index_ok  = 32'(rx_byte) < NUM_REGS;
    assign ptr_inc   = (ptr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
    assign cur_byte  = regs_q[ptr_q];
    assign next_byte = regs_q[ptr_inc];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        phase_d     = phase_q;
        rw_d        = rw_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        reg_we      = 1'b0;

        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            phase_d   = 1'b0;
        end else if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StIgnore: ;
                StAddr: begin
                    if (scl_rise) begin
                        shift_in_d = rx_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state_d = StAddrAck;
                                rw_d    = rx_byte[0];
                                phase_d = 1'b0;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                // Ack states see two falls: the first pulls SDA, the second closes.
                StAddrAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else if (rw_q) begin
                            state_d     = StRdata;
                            shift_out_d = cur_byte;
                            sda_oe_d    = ~cur_byte[7];
                            bit_cnt_d   = '0;
                            phase_d     = 1'b0;
                        end else begin
                            state_d   = StIndex;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            phase_d   = 1'b0;
                        end
                    end
                end
                StIndex: begin
                    if (scl_rise) begin
                        shift_in_d = rx_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (index_ok) begin
                                ptr_d   = rx_byte[ADDR_W-1:0];
                                state_d = StIndexAck;
                                phase_d = 1'b0;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                StIndexAck, StWdataAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            state_d   = StWdata;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            phase_d   = 1'b0;
                        end
                    end
                end
                StWdata: begin
                    if (scl_rise) begin
                        shift_in_d = rx_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d     = StWdataAck;
                            phase_d     = 1'b0;
                            reg_we      = 1'b1;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = ptr_q;
                            wr_data_d   = rx_byte;
                            ptr_d       = ptr_inc;
                        end
                    end
                end
                // phase_q set here means bit 7 of a freshly loaded byte is still to be driven.
                StRdata: begin
                    if (scl_fall) begin
                        if (phase_q) begin
                            sda_oe_d = ~shift_out_q[7];
                            phase_d  = 1'b0;
                        end else if (bit_cnt_q == 3'd7) begin
                            sda_oe_d  = 1'b0;
                            state_d   = StRdataAck;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d   = bit_cnt_q + 3'd1;
                            shift_out_d = shift_out_q << 1;
                            sda_oe_d    = ~shift_out_q[6];
                        end
                    end
                end
                StRdataAck: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_d       = ptr_inc;
                            shift_out_d = next_byte;
                            state_d     = StRdata;
                            bit_cnt_d   = '0;
                            phase_d     = 1'b1;
                        end else begin
                            state_d = StIgnore;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            phase_q     <= 1'b0;
            rw_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_data_q   <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            phase_q     <= phase_d;
            rw_q        <= rw_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_data_q   <= (32'(rd_addr) < NUM_REGS) ? regs_q[rd_addr] : 8'h00;
            if (reg_we) begin
                regs_q[ptr_q] <= rx_byte;
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign rd_data   = rd_data_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q >= StAddrAck) && (state_q <= StRdataAck);
    assign state     = state_q;

endmodule
